// File: rtl/bellek_hakem.sv
// bellek_hakem: arbitrates the L1B (instruction) and L1V (data) miss ports onto one memory port.
// Optional build macro BELLEK_HAKEM_DONUSUMLU_EN selects round-robin collision priority.
module bellek_hakem #(
  parameter int unsigned ADRES_GENISLIGI = 32,
  parameter int unsigned VERI_GENISLIGI  = 32,
  parameter int unsigned MASKE_GENISLIGI = VERI_GENISLIGI / 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // L1B miss port (read only)
  input  logic [ADRES_GENISLIGI-1:0] l1b_adres_i,
  input  logic                       l1b_gecerli_i,
  output logic [VERI_GENISLIGI-1:0]  l1b_veri_o,
  output logic                       l1b_hazir_o,
  // L1V miss port
  input  logic [ADRES_GENISLIGI-1:0] l1v_adres_i,
  input  logic                       l1v_gecerli_i,
  input  logic                       l1v_yaz_i,
  input  logic [MASKE_GENISLIGI-1:0] l1v_maske_i,
  input  logic [VERI_GENISLIGI-1:0]  l1v_veri_i,
  output logic [VERI_GENISLIGI-1:0]  l1v_veri_o,
  output logic                       l1v_hazir_o,
  // lower-level memory port
  output logic [ADRES_GENISLIGI-1:0] bellek_adres_o,
  output logic                       bellek_gecerli_o,
  output logic                       bellek_yaz_o,
  output logic [MASKE_GENISLIGI-1:0] bellek_maske_o,
  output logic [VERI_GENISLIGI-1:0]  bellek_veri_o,
  input  logic [VERI_GENISLIGI-1:0]  bellek_veri_i,
  input  logic                       bellek_hazir_i
);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    YANIT = 2'd2
  } durum_e;

  durum_e                     durum_q, durum_d;
  logic                       kimlik_q, kimlik_d;   // winner: 0 = L1B, 1 = L1V
  logic [ADRES_GENISLIGI-1:0] adres_q, adres_d;
  logic                       yaz_q, yaz_d;
  logic [MASKE_GENISLIGI-1:0] maske_q, maske_d;
  logic [VERI_GENISLIGI-1:0]  yveri_q, yveri_d;
  logic                       gecerli_q, gecerli_d;
  logic                       l1b_hazir_q, l1b_hazir_d;
  logic                       l1v_hazir_q, l1v_hazir_d;
  logic [VERI_GENISLIGI-1:0]  l1b_veri_q, l1b_veri_d;
  logic [VERI_GENISLIGI-1:0]  l1v_veri_q, l1v_veri_d;
  logic                       l1v_secilir;

`ifdef BELLEK_HAKEM_DONUSUMLU_EN
  // Reset value 0 means L1V is preferred on a collision.
  logic oncelik_b_q, oncelik_b_d;
  assign l1v_secilir = l1v_gecerli_i && !(l1b_gecerli_i && oncelik_b_q);
`else
  assign l1v_secilir = l1v_gecerli_i;
`endif

  // Next-state and registered-output logic
  always_comb begin
    durum_d     = durum_q;
    kimlik_d    = kimlik_q;
    adres_d     = adres_q;
    yaz_d       = yaz_q;
    maske_d     = maske_q;
    yveri_d     = yveri_q;
    gecerli_d   = gecerli_q;
    l1b_hazir_d = 1'b0;
    l1v_hazir_d = 1'b0;
    l1b_veri_d  = l1b_veri_q;
    l1v_veri_d  = l1v_veri_q;
`ifdef BELLEK_HAKEM_DONUSUMLU_EN
    oncelik_b_d = oncelik_b_q;
`endif

    unique case (durum_q)
      BOSTA: begin
        if (l1b_gecerli_i || l1v_gecerli_i) begin
          kimlik_d  = l1v_secilir;
          adres_d   = l1v_secilir ? l1v_adres_i : l1b_adres_i;
          yaz_d     = l1v_secilir && l1v_yaz_i;
          maske_d   = l1v_secilir ? l1v_maske_i : '1;
          yveri_d   = l1v_secilir ? l1v_veri_i : '0;
          gecerli_d = 1'b1;
          durum_d   = ISTEK;
        end
      end

      ISTEK: begin
        if (bellek_hazir_i) begin
          gecerli_d = 1'b0;
          durum_d   = YANIT;
          if (kimlik_q) begin
            l1v_hazir_d = 1'b1;
            l1v_veri_d  = yaz_q ? '0 : bellek_veri_i;
          end else begin
            l1b_hazir_d = 1'b1;
            l1b_veri_d  = bellek_veri_i;
          end
        end
      end

      YANIT: begin
        // Requests still held during the response cycle are not re-sampled here.
        durum_d = BOSTA;
`ifdef BELLEK_HAKEM_DONUSUMLU_EN
        oncelik_b_d = kimlik_q;
`endif
      end

      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q     <= BOSTA;
      kimlik_q    <= 1'b0;
      adres_q     <= '0;
      yaz_q       <= 1'b0;
      maske_q     <= '0;
      yveri_q     <= '0;
      gecerli_q   <= 1'b0;
      l1b_hazir_q <= 1'b0;
      l1v_hazir_q <= 1'b0;
      l1b_veri_q  <= '0;
      l1v_veri_q  <= '0;
`ifdef BELLEK_HAKEM_DONUSUMLU_EN
      oncelik_b_q <= 1'b0;
`endif
    end else begin
      durum_q     <= durum_d;
      kimlik_q    <= kimlik_d;
      adres_q     <= adres_d;
      yaz_q       <= yaz_d;
      maske_q     <= maske_d;
      yveri_q     <= yveri_d;
      gecerli_q   <= gecerli_d;
      l1b_hazir_q <= l1b_hazir_d;
      l1v_hazir_q <= l1v_hazir_d;
      l1b_veri_q  <= l1b_veri_d;
      l1v_veri_q  <= l1v_veri_d;
`ifdef BELLEK_HAKEM_DONUSUMLU_EN
      oncelik_b_q <= oncelik_b_d;
`endif
    end
  end

  assign bellek_adres_o   = adres_q;
  assign bellek_gecerli_o = gecerli_q;
  assign bellek_yaz_o     = yaz_q;
  assign bellek_maske_o   = maske_q;
  assign bellek_veri_o    = yveri_q;
  assign l1b_hazir_o      = l1b_hazir_q;
  assign l1b_veri_o       = l1b_veri_q;
  assign l1v_hazir_o      = l1v_hazir_q;
  assign l1v_veri_o       = l1v_veri_q;

endmodule

// File: tb/tb_bellek_hakem.sv
// tb_bellek_hakem: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_bellek_hakem;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [AW-1:0] l1b_adres_i = '0;
  logic          l1b_gecerli_i = 1'b0;
  logic [DW-1:0] l1b_veri_o;
  logic          l1b_hazir_o;
  logic [AW-1:0] l1v_adres_i = '0;
  logic          l1v_gecerli_i = 1'b0;
  logic          l1v_yaz_i = 1'b0;
  logic [MW-1:0] l1v_maske_i = '0;
  logic [DW-1:0] l1v_veri_i = '0;
  logic [DW-1:0] l1v_veri_o;
  logic          l1v_hazir_o;
  logic [AW-1:0] bellek_adres_o;
  logic          bellek_gecerli_o;
  logic          bellek_yaz_o;
  logic [MW-1:0] bellek_maske_o;
  logic [DW-1:0] bellek_veri_o;
  logic [DW-1:0] bellek_veri_i = '0;
  logic          bellek_hazir_i = 1'b0;

  int   n_chk = 0;
  int   n_pass = 0;
  logic pref_v = 1'b1;  // round-robin model: 1 = L1V preferred on collision

  bellek_hakem dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .l1b_adres_i(l1b_adres_i), .l1b_gecerli_i(l1b_gecerli_i),
    .l1b_veri_o(l1b_veri_o), .l1b_hazir_o(l1b_hazir_o),
    .l1v_adres_i(l1v_adres_i), .l1v_gecerli_i(l1v_gecerli_i), .l1v_yaz_i(l1v_yaz_i),
    .l1v_maske_i(l1v_maske_i), .l1v_veri_i(l1v_veri_i),
    .l1v_veri_o(l1v_veri_o), .l1v_hazir_o(l1v_hazir_o),
    .bellek_adres_o(bellek_adres_o), .bellek_gecerli_o(bellek_gecerli_o),
    .bellek_yaz_o(bellek_yaz_o), .bellek_maske_o(bellek_maske_o),
    .bellek_veri_o(bellek_veri_o), .bellek_veri_i(bellek_veri_i),
    .bellek_hazir_i(bellek_hazir_i)
  );

  always #5 clk_i = ~clk_i;

  // One cycle: outputs are sampled and inputs driven 1ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    l1b_adres_i = '0; l1b_gecerli_i = 1'b0;
    l1v_adres_i = '0; l1v_gecerli_i = 1'b0; l1v_yaz_i = 1'b0;
    l1v_maske_i = '0; l1v_veri_i = '0;
    bellek_veri_i = '0; bellek_hazir_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    pref_v = 1'b1;
  endtask

  task automatic test_reset();
    idle_in();
    rst_i = 1'b1;
    step();
    step();
    n_chk++;
    if ({bellek_gecerli_o, bellek_yaz_o, bellek_adres_o, bellek_maske_o, bellek_veri_o} !== 70'h0)
      $display("FAIL reset_mem: got %h expected 0",
               {bellek_gecerli_o, bellek_yaz_o, bellek_adres_o, bellek_maske_o, bellek_veri_o});
    else n_pass++;
    n_chk++;
    if ({l1b_hazir_o, l1b_veri_o, l1v_hazir_o, l1v_veri_o} !== 66'h0)
      $display("FAIL reset_l1: got %h expected 0", {l1b_hazir_o, l1b_veri_o, l1v_hazir_o, l1v_veri_o});
    else n_pass++;
    l1b_gecerli_i = 1'b1; l1b_adres_i = 32'h0000_0040;
    step();
    step();
    n_chk++;
    if (bellek_gecerli_o !== 1'b0) $display("FAIL reset_hold_gec: got %b expected 0", bellek_gecerli_o);
    else n_pass++;
    rst_i = 1'b0;
    idle_in();
    step();
  endtask

  task automatic test_single_read();
    do_reset();
    l1b_adres_i = 32'h0000_1000; l1b_gecerli_i = 1'b1;
    step();
    n_chk++;
    if ({bellek_gecerli_o, bellek_adres_o, bellek_yaz_o, bellek_maske_o} !== {1'b1, 32'h0000_1000, 1'b0, 4'hF})
      $display("FAIL read_req: got gec=%b adr=%h yaz=%b mask=%h expected 1 00001000 0 f",
               bellek_gecerli_o, bellek_adres_o, bellek_yaz_o, bellek_maske_o);
    else n_pass++;
    step();
    n_chk++;
    if ({bellek_gecerli_o, l1b_hazir_o} !== 2'b10)
      $display("FAIL read_wait: got gec=%b hazir=%b expected 1 0", bellek_gecerli_o, l1b_hazir_o);
    else n_pass++;
    bellek_hazir_i = 1'b1; bellek_veri_i = 32'hDEAD_BEEF;
    step();
    bellek_hazir_i = 1'b0; bellek_veri_i = '0;
    n_chk++;
    if ({l1b_hazir_o, l1b_veri_o, l1v_hazir_o, bellek_gecerli_o} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0})
      $display("FAIL read_resp: got bh=%b bveri=%h vh=%b gec=%b expected 1 deadbeef 0 0",
               l1b_hazir_o, l1b_veri_o, l1v_hazir_o, bellek_gecerli_o);
    else n_pass++;
    l1b_gecerli_i = 1'b0;
    step();
    n_chk++;
    if ({l1b_hazir_o, l1b_veri_o} !== {1'b0, 32'hDEAD_BEEF})
      $display("FAIL read_after: got bh=%b bveri=%h expected 0 deadbeef", l1b_hazir_o, l1b_veri_o);
    else n_pass++;
  endtask

  task automatic test_write_stall();
    do_reset();
    l1v_adres_i = 32'h2000_0004; l1v_veri_i = 32'h1234_5678; l1v_maske_i = 4'h3;
    l1v_yaz_i = 1'b1; l1v_gecerli_i = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({bellek_gecerli_o, bellek_adres_o, bellek_yaz_o, bellek_maske_o, bellek_veri_o, l1v_hazir_o}
          !== {1'b1, 32'h2000_0004, 1'b1, 4'h3, 32'h1234_5678, 1'b0})
        $display("FAIL write_hold[%0d]: got gec=%b adr=%h yaz=%b m=%h d=%h vh=%b expected 1 20000004 1 3 12345678 0",
                 i, bellek_gecerli_o, bellek_adres_o, bellek_yaz_o, bellek_maske_o, bellek_veri_o, l1v_hazir_o);
      else n_pass++;
      if (i == 4) begin bellek_hazir_i = 1'b1; bellek_veri_i = 32'hA5A5_A5A5; end
      step();
    end
    bellek_hazir_i = 1'b0;
    n_chk++;
    if ({l1v_hazir_o, l1v_veri_o, l1b_hazir_o, bellek_gecerli_o} !== {1'b1, 32'h0, 1'b0, 1'b0})
      $display("FAIL write_resp: got vh=%b vveri=%h bh=%b gec=%b expected 1 0 0 0",
               l1v_hazir_o, l1v_veri_o, l1b_hazir_o, bellek_gecerli_o);
    else n_pass++;
    l1v_gecerli_i = 1'b0;
    step();
    n_chk++;
    if (l1v_hazir_o !== 1'b0) $display("FAIL write_single_pulse: got %b expected 0", l1v_hazir_o);
    else n_pass++;
  endtask

  task automatic test_collision();
    int   sira[$];
    int   puls_c[$];
    int   yuks_c[$];
    logic p_gec, b_drop, v_drop;
    int   hedef;
`ifdef BELLEK_HAKEM_DONUSUMLU_EN
    hedef = 4;
`else
    hedef = 2;
`endif
    do_reset();
    l1b_adres_i = 32'h0000_B000; l1v_adres_i = 32'h0000_C000;
    l1b_gecerli_i = 1'b1; l1v_gecerli_i = 1'b1;
    p_gec = 1'b0; b_drop = 1'b0; v_drop = 1'b0;
    for (int c = 0; c < 40 && int'(sira.size()) < hedef; c++) begin
      if (bellek_gecerli_o && !p_gec) yuks_c.push_back(c);
      if (l1b_hazir_o) begin sira.push_back(0); puls_c.push_back(c); end
      if (l1v_hazir_o) begin sira.push_back(1); puls_c.push_back(c); end
      p_gec = bellek_gecerli_o;
      bellek_hazir_i = bellek_gecerli_o; bellek_veri_i = 32'(c);
`ifndef BELLEK_HAKEM_DONUSUMLU_EN
      if (b_drop) l1b_gecerli_i = 1'b0;
      if (v_drop) l1v_gecerli_i = 1'b0;
      b_drop = l1b_hazir_o; v_drop = l1v_hazir_o;
`endif
      step();
    end
    n_chk++;
    if (int'(sira.size()) !== hedef) $display("FAIL coll_count: got %0d expected %0d", sira.size(), hedef);
    else n_pass++;
    for (int i = 0; i < int'(sira.size()); i++) begin
      n_chk++;
      if (sira[i] !== ((i % 2 == 0) ? 1 : 0))
        $display("FAIL coll_order[%0d]: got %0d expected %0d", i, sira[i], (i % 2 == 0) ? 1 : 0);
      else n_pass++;
    end
    if (yuks_c.size() >= 2 && puls_c.size() >= 1) begin
      n_chk++;
      if (yuks_c[1] !== puls_c[0] + 2)
        $display("FAIL coll_second_grant: got cycle %0d expected %0d", yuks_c[1], puls_c[0] + 2);
      else n_pass++;
    end
    idle_in();
    step();
    step();
  endtask

  task automatic test_addr_change();
    do_reset();
    l1v_adres_i = 32'h0000_0100; l1v_yaz_i = 1'b0; l1v_maske_i = 4'hF; l1v_gecerli_i = 1'b1;
    step();
    l1v_adres_i = 32'h0000_3000; l1v_yaz_i = 1'b1; l1v_maske_i = 4'h1; l1v_veri_i = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({bellek_gecerli_o, bellek_adres_o, bellek_yaz_o, bellek_maske_o} !== {1'b1, 32'h0000_0100, 1'b0, 4'hF})
        $display("FAIL addr_hold[%0d]: got gec=%b adr=%h yaz=%b m=%h expected 1 00000100 0 f",
                 i, bellek_gecerli_o, bellek_adres_o, bellek_yaz_o, bellek_maske_o);
      else n_pass++;
    end
    bellek_hazir_i = 1'b1; bellek_veri_i = 32'h0BAD_F00D;
    step();
    bellek_hazir_i = 1'b0;
    n_chk++;
    if ({l1v_hazir_o, l1v_veri_o} !== {1'b1, 32'h0BAD_F00D})
      $display("FAIL addr_resp: got vh=%b vveri=%h expected 1 0badf00d", l1v_hazir_o, l1v_veri_o);
    else n_pass++;
    idle_in();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    l1b_adres_i = 32'h0000_4000; l1b_gecerli_i = 1'b1;
    step();
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    n_chk++;
    if ({bellek_gecerli_o, bellek_adres_o, bellek_maske_o, l1b_hazir_o, l1v_hazir_o} !== 39'h0)
      $display("FAIL midreset_zero: got gec=%b adr=%h m=%h bh=%b vh=%b expected all 0",
               bellek_gecerli_o, bellek_adres_o, bellek_maske_o, l1b_hazir_o, l1v_hazir_o);
    else n_pass++;
    step();
    n_chk++;
    if ({bellek_gecerli_o, bellek_adres_o} !== {1'b1, 32'h0000_4000})
      $display("FAIL midreset_regrant: got gec=%b adr=%h expected 1 00004000", bellek_gecerli_o, bellek_adres_o);
    else n_pass++;
    bellek_hazir_i = 1'b1; bellek_veri_i = 32'h600D_CAFE;
    step();
    bellek_hazir_i = 1'b0;
    n_chk++;
    if ({l1b_hazir_o, l1b_veri_o} !== {1'b1, 32'h600D_CAFE})
      $display("FAIL midreset_resp: got bh=%b bveri=%h expected 1 600dcafe", l1b_hazir_o, l1b_veri_o);
    else n_pass++;
    idle_in();
    step();
  endtask

  task automatic test_spurious();
    do_reset();
    bellek_hazir_i = 1'b1; bellek_veri_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({bellek_gecerli_o, l1b_hazir_o, l1v_hazir_o, l1b_veri_o, l1v_veri_o} !== 67'h0)
        $display("FAIL spurious[%0d]: got gec=%b bh=%b vh=%b bveri=%h vveri=%h expected all 0",
                 i, bellek_gecerli_o, l1b_hazir_o, l1v_hazir_o, l1b_veri_o, l1v_veri_o);
      else n_pass++;
    end
    bellek_hazir_i = 1'b0;
    l1v_adres_i = 32'h0000_0800; l1v_gecerli_i = 1'b1;
    step();
    bellek_hazir_i = 1'b1; bellek_veri_i = 32'h1357_9BDF;
    step();
    bellek_hazir_i = 1'b0;
    n_chk++;
    if ({l1v_hazir_o, l1v_veri_o} !== {1'b1, 32'h1357_9BDF})
      $display("FAIL min_latency: got vh=%b vveri=%h expected 1 13579bdf", l1v_hazir_o, l1v_veri_o);
    else n_pass++;
    idle_in();
    step();
  endtask

  task automatic test_random(input int n_cyc);
    logic          b_v, v_v, v_w, p_b_v, p_v_v, p_v_w;
    logic [AW-1:0] b_a, v_a, p_b_a, p_v_a, g_a;
    logic [DW-1:0] v_d, p_v_d, g_d, p_hz_veri, hz_veri, e_bveri, e_vveri;
    logic [MW-1:0] v_m, p_v_m, g_m;
    logic          p_gec, p_puls, p_hz, gnt, g_w, tamam, e_gec, gec, b_rel, v_rel, hz;
    int            mem_cnt, b_bekle, v_bekle;
    do_reset();
    b_v = 0; v_v = 0; v_w = 0; b_a = '0; v_a = '0; v_d = '0; v_m = '0;
    p_b_v = 0; p_v_v = 0; p_v_w = 0; p_b_a = '0; p_v_a = '0; p_v_d = '0; p_v_m = '0;
    p_gec = 0; p_puls = 0; p_hz = 0; p_hz_veri = '0; gnt = 0; g_w = 0;
    g_a = '0; g_d = '0; g_m = '0; e_bveri = '0; e_vveri = '0;
    b_rel = 0; v_rel = 0; mem_cnt = 0; b_bekle = 0; v_bekle = 0;
    for (int c = 0; c < n_cyc; c++) begin
      // Expected memory-port activity from last cycle's observable state
      gec   = bellek_gecerli_o;
      tamam = p_gec && p_hz;
      e_gec = p_gec ? !tamam : (p_puls ? 1'b0 : (p_b_v || p_v_v));
      n_chk++;
      if (gec !== e_gec) $display("FAIL rnd_gec@%0d: got %b expected %b", c, gec, e_gec);
      else n_pass++;
      if (gec && !p_gec) begin
`ifdef BELLEK_HAKEM_DONUSUMLU_EN
        gnt = (p_b_v && p_v_v) ? pref_v : p_v_v;
`else
        gnt = p_v_v;
`endif
        g_a = gnt ? p_v_a : p_b_a;
        g_w = gnt && p_v_w;
        g_m = gnt ? p_v_m : 4'hF;
        g_d = p_v_d;
        mem_cnt = int'($urandom_range(0, 4));
      end
      if (gec) begin
        n_chk++;
        if ({bellek_adres_o, bellek_yaz_o, bellek_maske_o} !== {g_a, g_w, g_m} ||
            (gnt && bellek_veri_o !== g_d))
          $display("FAIL rnd_fields@%0d: got adr=%h yaz=%b m=%h d=%h expected %h %b %h %h",
                   c, bellek_adres_o, bellek_yaz_o, bellek_maske_o, bellek_veri_o, g_a, g_w, g_m, g_d);
        else n_pass++;
      end
      if (tamam) begin
        if (gnt) e_vveri = g_w ? '0 : p_hz_veri;
        else     e_bveri = p_hz_veri;
        pref_v = !gnt;
      end
      n_chk++;
      if ({l1b_hazir_o, l1v_hazir_o} !== {tamam && !gnt, tamam && gnt})
        $display("FAIL rnd_hazir@%0d: got b=%b v=%b expected %b %b",
                 c, l1b_hazir_o, l1v_hazir_o, tamam && !gnt, tamam && gnt);
      else n_pass++;
      n_chk++;
      if ({l1b_veri_o, l1v_veri_o} !== {e_bveri, e_vveri})
        $display("FAIL rnd_veri@%0d: got b=%h v=%h expected %h %h", c, l1b_veri_o, l1v_veri_o, e_bveri, e_vveri);
      else n_pass++;

      // Requesters hold until their pulse, keep it through the pulse cycle, then choose again
      if (b_rel) begin
        b_rel = 0; b_v = ($urandom % 2) == 0; b_a = $urandom; b_bekle = 0;
      end else if (b_v && l1b_hazir_o) b_rel = 1;
      else if (!b_v && ($urandom % 3) == 0) begin
        b_v = 1; b_a = $urandom; b_bekle = 0;
      end
      if (v_rel) begin
        v_rel = 0; v_v = ($urandom % 4) == 0; v_bekle = 0;
        v_a = $urandom; v_d = $urandom; v_w = $urandom_range(0, 1) == 1; v_m = MW'($urandom);
      end else if (v_v && l1v_hazir_o) v_rel = 1;
      else if (!v_v && ($urandom % 3) == 0) begin
        v_v = 1; v_bekle = 0;
        v_a = $urandom; v_d = $urandom; v_w = $urandom_range(0, 1) == 1; v_m = MW'($urandom);
      end
      if (b_v && !l1b_hazir_o) b_bekle++;
      if (v_v && !l1v_hazir_o) v_bekle++;
      if (b_bekle > 200 || v_bekle > 200) begin
        n_chk++;
        $display("FAIL rnd_timeout@%0d: waits b=%0d v=%0d expected <= 200", c, b_bekle, v_bekle);
        b_bekle = 0; v_bekle = 0;
      end

      // Memory: completes after a random delay, occasionally pulses hazir while idle
      if (gec) begin
        if (mem_cnt == 0) begin hz = 1; mem_cnt = 99; end
        else begin hz = 0; mem_cnt--; end
      end else hz = ($urandom % 6) == 0;
      hz_veri = $urandom;

      l1b_gecerli_i = b_v; l1b_adres_i = b_a;
      l1v_gecerli_i = v_v; l1v_adres_i = v_a; l1v_veri_i = v_d; l1v_yaz_i = v_w; l1v_maske_i = v_m;
      bellek_hazir_i = hz; bellek_veri_i = hz_veri;
      p_b_v = b_v; p_b_a = b_a; p_v_v = v_v; p_v_a = v_a; p_v_d = v_d; p_v_w = v_w; p_v_m = v_m;
      p_gec = gec; p_puls = tamam; p_hz = hz; p_hz_veri = hz_veri;
      step();
    end
    idle_in();
    step();
  endtask

  initial begin
    step();
    test_reset();
    test_single_read();
    test_write_stall();
    test_collision();
    test_addr_change();
    test_reset_mid();
    test_spurious();
    test_random(3000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
